// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared state encoding and widths for the memory bus responder
package mem_bus_pkg;

  localparam int ADDR_BUS_W = 16;
  localparam int DATA_W     = 8;
  localparam int CNT_W      = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LATCHED = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ACCESS  = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

endpackage

// File: rtl/resp_ram.sv
// rtl/resp_ram.sv - single-port synchronous RAM with registered read
module resp_ram
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Read-first port: dout always reflects the addressed byte one edge later.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - 8085-style AD bus memory responder with wait states
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int                    ADDR_W      = 10,
  parameter logic [ADDR_BUS_W-1:0] BASE_ADDR   = 16'h0000,
  parameter int                    WAIT_STATES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ale,
  input  logic [7:0]        addr_hi,
  input  logic [7:0]        ad_in,
  input  logic              io_m,
  input  logic              rd_n,
  input  logic              wr_n,
  output logic [DATA_W-1:0] ad_out,
  output logic              ad_oe,
  output logic              ready,
  output logic              bus_err
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);

  state_t                  state;
  state_t                  state_nx;
  logic [ADDR_BUS_W-1:0]   addr_q;
  logic [ADDR_BUS_W-1:0]   bus_addr;
  logic                    io_m_q;
  logic                    is_wr_q;
  logic                    wr_nx;
  logic [CNT_W-1:0]        cnt;
  logic                    sel;
  logic                    enter_access;
  logic                    load_cnt;
  logic                    set_err;
  logic                    ram_we;
  logic [ADDR_W-1:0]       ram_addr;
  logic [DATA_W-1:0]       ram_dout;

  assign bus_addr = {addr_hi, ad_in};
  assign sel      = !io_m_q && (addr_q[ADDR_BUS_W-1:ADDR_W] == BASE_ADDR[ADDR_BUS_W-1:ADDR_W]);
  assign ready    = (state != ST_WAIT);

  // The RAM looks at the incoming address during ALE so read data is already
  // registered by the time a zero-wait access enters ACCESS one edge later.
  assign ram_addr = ale ? bus_addr[ADDR_W-1:0] : addr_q[ADDR_W-1:0];
  assign ram_we   = enter_access && wr_nx;

  resp_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clock (clock),
    .we    (ram_we),
    .addr  (ram_addr),
    .din   (ad_in),
    .dout  (ram_dout)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and per-edge action strobes; ALE overrides everything.
  always_comb begin
    state_nx     = state;
    enter_access = 1'b0;
    load_cnt     = 1'b0;
    set_err      = 1'b0;
    wr_nx        = is_wr_q;
    if (ale) begin
      state_nx = ST_LATCHED;
    end else begin
      case (state)
        ST_IDLE: state_nx = ST_IDLE;
        ST_LATCHED: begin
          if (!sel) begin
            state_nx = ST_IDLE;
          end else if (!rd_n && !wr_n) begin
            state_nx = ST_HOLD;
            set_err  = 1'b1;
          end else if (!rd_n || !wr_n) begin
            wr_nx = !wr_n;
            if (WAIT_STATES == 0) begin
              state_nx     = ST_ACCESS;
              enter_access = 1'b1;
            end else begin
              state_nx = ST_WAIT;
              load_cnt = 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (rd_n && wr_n) begin
            state_nx = ST_IDLE;
          end else if (cnt == '0) begin
            state_nx     = ST_ACCESS;
            enter_access = 1'b1;
          end
        end
        ST_ACCESS: if (rd_n && wr_n) state_nx = ST_IDLE;
        ST_HOLD:   if (rd_n && wr_n) state_nx = ST_IDLE;
        default:   state_nx = ST_IDLE;
      endcase
    end
  end

  // Address latch, wait counter, read data and sticky error flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      io_m_q  <= 1'b0;
      is_wr_q <= 1'b0;
      cnt     <= '0;
      ad_out  <= '0;
      ad_oe   <= 1'b0;
      bus_err <= 1'b0;
    end else if (ale) begin
      addr_q <= bus_addr;
      io_m_q <= io_m;
      ad_oe  <= 1'b0;
    end else begin
      is_wr_q <= wr_nx;
      if (load_cnt) begin
        cnt <= WAIT_INIT;
      end else if (state == ST_WAIT && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (enter_access && !wr_nx) begin
        ad_out <= ram_dout;
        ad_oe  <= 1'b1;
      end else if (state_nx != ST_ACCESS) begin
        ad_oe <= 1'b0;
      end
      if (set_err) begin
        bus_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// tb/tb_mem_bus_responder.sv - scoreboard bench for mem_bus_responder
module tb_mem_bus_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ale = 1'b0;
  logic [7:0]  addr_hi = 8'h00;
  logic [7:0]  ad_in = 8'h00;
  logic        io_m = 1'b0;
  logic        rd_n = 1'b1;
  logic        wr_n = 1'b1;
  logic [23:0] ad_out_v;
  logic [2:0]  ad_oe_v;
  logic [2:0]  ready_v;
  logic [2:0]  err_v;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  model [3][1024];
  logic [7:0]  exp_q [$];

  always #5 clock = ~clock;

  // Three windows sharing one bus: 0x0000 (1 wait), 0x0400 (0 wait), 0x0800 (3 wait).
  mem_bus_responder #(.ADDR_W(10), .BASE_ADDR(16'h0000), .WAIT_STATES(1)) u_ws1 (
    .clock(clock), .reset(reset), .ale(ale), .addr_hi(addr_hi), .ad_in(ad_in),
    .io_m(io_m), .rd_n(rd_n), .wr_n(wr_n), .ad_out(ad_out_v[7:0]),
    .ad_oe(ad_oe_v[0]), .ready(ready_v[0]), .bus_err(err_v[0]));

  mem_bus_responder #(.ADDR_W(10), .BASE_ADDR(16'h0400), .WAIT_STATES(0)) u_ws0 (
    .clock(clock), .reset(reset), .ale(ale), .addr_hi(addr_hi), .ad_in(ad_in),
    .io_m(io_m), .rd_n(rd_n), .wr_n(wr_n), .ad_out(ad_out_v[15:8]),
    .ad_oe(ad_oe_v[1]), .ready(ready_v[1]), .bus_err(err_v[1]));

  mem_bus_responder #(.ADDR_W(10), .BASE_ADDR(16'h0800), .WAIT_STATES(3)) u_ws3 (
    .clock(clock), .reset(reset), .ale(ale), .addr_hi(addr_hi), .ad_in(ad_in),
    .io_m(io_m), .rd_n(rd_n), .wr_n(wr_n), .ad_out(ad_out_v[23:16]),
    .ad_oe(ad_oe_v[2]), .ready(ready_v[2]), .bus_err(err_v[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ws_of(input int i);
    case (i)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  function automatic logic [7:0] dout_of(input int i);
    return ad_out_v[i*8 +: 8];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic latch(input logic [15:0] a, input logic iom);
    ale = 1'b1; addr_hi = a[15:8]; ad_in = a[7:0]; io_m = iom; rd_n = 1'b1; wr_n = 1'b1;
    tick();
    ale = 1'b0; io_m = 1'b0;
  endtask

  task automatic bus_write(input int i, input logic [15:0] a, input logic [7:0] d);
    int waits;
    latch(a, 1'b0);
    wr_n = 1'b0; ad_in = d;
    tick();
    waits = 0;
    while (waits < 40 && !ready_v[i]) begin
      waits++;
      tick();
    end
    check("wr_waits", waits, ws_of(i));
    ad_in = ~d;
    tick();
    wr_n = 1'b1;
    tick();
    model[i][a[9:0]] = d;
    check("wr_ready_idle", ready_v[i], 1);
  endtask

  task automatic bus_read(input int i, input logic [15:0] a, input bit do_latch);
    int waits;
    int n;
    if (do_latch) latch(a, 1'b0);
    exp_q.push_back(model[i][a[9:0]]);
    rd_n = 1'b0;
    tick();
    waits = 0;
    n = 0;
    while (n < 40 && !ad_oe_v[i]) begin
      if (!ready_v[i]) waits++;
      n++;
      tick();
    end
    check("rd_oe", ad_oe_v[i], 1);
    check("rd_waits", waits, ws_of(i));
    check("rd_latency", n, ws_of(i));
    check("rd_data", dout_of(i), exp_q.pop_front());
    tick();
    check("rd_oe_hold", ad_oe_v[i], 1);
    rd_n = 1'b1;
    tick();
    check("rd_oe_drop", ad_oe_v[i], 0);
  endtask

  initial begin
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      check("rst_ad_out", dout_of(i), 8'h00);
      check("rst_ad_oe", ad_oe_v[i], 0);
      check("rst_ready", ready_v[i], 1);
      check("rst_bus_err", err_v[i], 0);
    end
    reset = 1'b1;
    tick();

    bus_write(0, 16'h0123, 8'hA5);
    bus_read(0, 16'h0123, 1'b1);
    bus_write(1, 16'h0410, 8'h3C);
    bus_read(1, 16'h0410, 1'b1);

    latch(16'h0400, 1'b0);
    rd_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("oow_ad_oe", ad_oe_v[0], 0);
      check("oow_ready", ready_v[0], 1);
    end
    rd_n = 1'b1;
    tick();

    latch(16'h0005, 1'b1);
    rd_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("io_ad_oe", ad_oe_v[0], 0);
      check("io_ready", ready_v[0], 1);
    end
    rd_n = 1'b1;
    tick();

    bus_write(0, 16'h0001, 8'h11);
    latch(16'h0001, 1'b0);
    rd_n = 1'b0; wr_n = 1'b0; ad_in = 8'hEE;
    tick();
    check("both_err", err_v[0], 1);
    check("both_ad_oe", ad_oe_v[0], 0);
    check("both_ready", ready_v[0], 1);
    tick();
    rd_n = 1'b1; wr_n = 1'b1;
    tick();
    bus_read(0, 16'h0001, 1'b1);
    check("err_sticky", err_v[0], 1);
    check("err_other", err_v[2:1], 2'b00);

    bus_write(2, 16'h0820, 8'h5A);
    latch(16'h0820, 1'b0);
    wr_n = 1'b0; ad_in = 8'h77;
    tick();
    check("rel_wait", ready_v[2], 0);
    tick();
    wr_n = 1'b1;
    tick();
    check("rel_ready", ready_v[2], 1);
    tick();
    bus_read(2, 16'h0820, 1'b1);

    bus_write(2, 16'h0821, 8'h01);
    bus_write(2, 16'h0822, 8'h02);
    latch(16'h0821, 1'b0);
    wr_n = 1'b0; ad_in = 8'h99;
    tick();
    check("relatch_wait", ready_v[2], 0);
    tick();
    ale = 1'b1; addr_hi = 8'h08; ad_in = 8'h22;
    tick();
    ale = 1'b0; wr_n = 1'b1;
    bus_read(2, 16'h0822, 1'b0);
    bus_read(2, 16'h0821, 1'b1);

    bus_write(2, 16'h0830, 8'h44);
    latch(16'h0830, 1'b0);
    wr_n = 1'b0; ad_in = 8'hBB;
    tick();
    check("mid_wait", ready_v[2], 0);
    #2 reset = 1'b0;
    #1;
    check("mid_ad_oe", ad_oe_v, 3'b000);
    check("mid_ready", ready_v[2], 1);
    check("mid_bus_err", err_v[0], 0);
    check("mid_ad_out", dout_of(2), 8'h00);
    tick();
    tick();
    wr_n = 1'b1;
    reset = 1'b1;
    tick();
    bus_read(2, 16'h0830, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Memory-side responder for the processor's external address/data bus; it is the slave at the far end of the bus the core drives.
- Demultiplexes an 8085-style AD bus: latches the low address on ALE and the high address from addr_hi.
- Decodes a memory window, inserts programmable wait states via READY, and serves reads and writes from an internal synchronous RAM.
- Sits between the processor top and the board-level memory map; one instance per memory region.

Parameters:
ADDR_W, 10, RAM address width; the window is 2^ADDR_W bytes.
BASE_ADDR, 16'h0000, window base; must be aligned to 2^ADDR_W.
WAIT_STATES, 1, number of READY-low cycles per access (0..15).

Ports:
clock  in  1  system clock; all bus inputs sampled on the rising edge.
reset  in  1  asynchronous, active-low reset.
ale  in  1  address latch enable; high for one cycle at the start of a bus cycle.
addr_hi  in  8  A15..A8.
ad_in  in  8  multiplexed AD7..AD0 input: address when ale=1, write data otherwise.
io_m  in  1  1=I/O cycle (never selected), 0=memory cycle.
rd_n  in  1  read strobe, active low.
wr_n  in  1  write strobe, active low.
ad_out  out  8  read data.
ad_oe  out  1  ad_out drive enable.
ready  out  1  0 inserts a wait state.
bus_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; ad_out=8'h00; ad_oe=0; ready=1; bus_err=0; latched address=0.
  - RAM contents are not reset.
- States: IDLE, LATCHED, WAIT, ACCESS, HOLD.
- ALE capture:
  - Any edge with ale=1, in any state, latches addr={addr_hi,ad_in} and io_m, clears ad_oe, and enters LATCHED.
  - A write not yet performed is aborted.
- sel = (io_m==0) && (addr[15:ADDR_W]==BASE_ADDR[15:ADDR_W]).
- LATCHED:
  - !sel -> IDLE.
  - sel and rd_n=0, wr_n=0 -> HOLD; set bus_err.
  - sel and exactly one strobe low -> WAIT with cnt=WAIT_STATES-1. If WAIT_STATES=0, go straight to ACCESS.
  - No strobe -> stay in LATCHED.
- WAIT:
  - Both strobes high -> IDLE (abort, no write).
  - cnt==0 -> ACCESS; otherwise cnt--.
  - ready=0 for exactly WAIT_STATES cycles.
- Entry edge into ACCESS:
  - Read: ad_out<=ram[addr[ADDR_W-1:0]]; ad_oe<=1.
  - Write: ram[addr]<=ad_in sampled on that edge, exactly once.
- ACCESS: stays until rd_n=1 and wr_n=1 are sampled; then -> IDLE with ad_oe<=0 on that edge. No repeat writes while wr_n is held low.
- HOLD: ad_oe=0; leaves to IDLE when both strobes are high.
- ready = (state != WAIT), decoded from registered state. It is 1 for unselected cycles.
- bus_err clears only on reset.
- Latency for a read with ale at edge E0 and rd_n low from E1: data is valid after edge E1+WAIT_STATES.
- Address arithmetic: only addr[ADDR_W-1:0] indexes RAM. There is no wrap inside the window; out-of-window addresses are ignored.

Decomposition:
- Package mem_bus_pkg: state encoding constants (IDLE..HOLD), bus width constants (ADDR_BUS_W=16, DATA_W=8), and the wait counter width (4).
- Sub-module resp_ram: single-port synchronous RAM (2^ADDR_W x 8) with clock, we, addr, din, dout, and a registered read.

Test Plan:
- Reset low mid-WAIT -> immediately ad_oe=0, ready=1, bus_err=0, state IDLE; the pending write does not occur (read back of the target byte is unchanged).
- WAIT_STATES=1:
  - Write: ale with addr 16'h0123, then wr_n low with ad_in=8'hA5 -> ready low exactly 1 cycle, then ACCESS.
  - Read back: ale addr 16'h0123, then rd_n low -> ready low 1 cycle, then ad_out=8'hA5 with ad_oe=1; ad_oe drops on the edge rd_n=1 is sampled.
- WAIT_STATES=0: ale addr 16'h0010, then rd_n low -> ready never low; ad_out valid one edge after rd_n is sampled low.
- Unselected cycles:
  - Out-of-window ale addr 16'h0400 (ADDR_W=10, BASE 0) with rd_n low -> ad_oe stays 0, ready stays 1, state returns to IDLE.
  - io_m=1 at address 16'h0005 -> same result.
- Protocol errors:
  - Both rd_n and wr_n low after ale at 16'h0001 -> bus_err=1 (sticky across later good cycles); no RAM change; ad_oe=0.
  - WAIT_STATES=3, wr_n released during WAIT -> no write.
  - New ale during WAIT -> re-latches the new address; the old write is aborted.
